// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART transmitter.
//   tx_state_e   serialiser FSM state encoding
//   PAR_*        runtime parity-mode codes (2'b11 behaves as PAR_NONE)
//   DIV_MIN      smallest usable clocks-per-bit value
//   par_enabled  true when a parity bit is part of the frame
//   par_bit      parity bit to send, given the XOR of all data bits
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned DIV_MIN = 32'd2;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  // Even mode sends the XOR of the word, odd mode its inverse.
  function automatic logic par_bit(input logic [1:0] mode, input logic xor_all);
    return (mode == PAR_ODD) ? ~xor_all : xor_all;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: word handshake between the service bus logic and the
// transmitter queue.
//   i_data   word offered for transmission
//   i_valid  word is being offered
//   o_ready  transmitter can take a word this cycle (queue not full)
// The master modport belongs to the word producer, slave to the transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular word queue in front of the serialiser.
//   i_wb_clk/i_rst_n  clock, asynchronous active-low reset
//   i_push/i_push_data  write a word (ignored while full)
//   i_pop/o_pop_data    read port; o_pop_data shows the head word
//   o_full/o_empty      occupancy flags
//   o_level             number of stored words
// FIFO_DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo #(
  parameter int  DATA_BITS  = 8,
  parameter int  FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                 i_wb_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_push_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_pop_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [LVL_W-1:0]     o_level
);

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]     level_r;
  logic                 push_s;
  logic                 pop_s;

  assign o_full     = (level_r == LVL_W'(FIFO_DEPTH));
  assign o_empty    = (level_r == {LVL_W{1'b0}});
  assign o_level    = level_r;
  assign o_pop_data = mem_r[rd_ptr_r];
  assign push_s     = i_push && !o_full;
  assign pop_s      = i_pop && !o_empty;

  // Storage array; cleared on reset so a flushed queue holds no stale words.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_BITS{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= i_push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the level alone.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: buffered UART transmitter with build-time word width and
// run-time divisor, parity and stop-bit count. Words are sent LSB first,
// queued words follow each other with no idle gap.
//   i_wb_clk/i_rst_n  clock, asynchronous active-low reset
//   bus               word handshake (i_data, i_valid, o_ready = !full)
//   i_div             clocks per bit; 0 and 1 behave as 2
//   i_parity          00 none, 01 odd, 10 even, 11 none
//   i_stop2           two stop bits when set
//   o_tx              registered serial line, idles high
//   o_busy            frame in flight or words queued
//   o_done            one-cycle pulse after each frame's last stop bit
//   o_level           queue occupancy
// Divisor, parity and stop setting are latched when a frame starts.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int  DATA_BITS  = 8,
  parameter int  FIFO_DEPTH = 4,
  parameter int  DIV_W      = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_wb_clk,
  input  logic             i_rst_n,
  uart_tx_cfg_if.slave     bus,
  input  logic [DIV_W-1:0] i_div,
  input  logic [1:0]       i_parity,
  input  logic             i_stop2,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic [LVL_W-1:0] o_level
);

  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);

  tx_state_e            state_r, state_s;
  logic [DIV_W-1:0]     cnt_r, cnt_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 par_acc_r, par_acc_s;
  logic                 stop_half_r, stop_half_s;
  logic [DIV_W-1:0]     div_r, div_s;
  logic [1:0]           par_mode_r, par_mode_s;
  logic                 stop2_r, stop2_s;
  logic                 tx_r, tx_s;
  logic                 done_r, done_s;
  logic                 busy_r, busy_s;
  logic                 load_s;

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [LVL_W-1:0]     fifo_level_s;
  logic [DATA_BITS-1:0] fifo_data_s;
  logic                 push_s;
  logic [DIV_W-1:0]     div_eff_s;
  logic                 bit_end_s;
  logic [LVL_W-1:0]     lvl_next_s;

  assign bus.o_ready = !fifo_full_s;
  assign push_s      = bus.i_valid && !fifo_full_s;
  assign div_eff_s   = (i_div < DIV_FLOOR) ? DIV_FLOOR : i_div;
  assign bit_end_s   = (cnt_r == (div_r - DIV_W'(1)));
  // Occupancy after this edge, so o_busy can be registered without lag.
  assign lvl_next_s  = fifo_level_s + LVL_W'(push_s) - LVL_W'(load_s);

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_wb_clk    (i_wb_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push_s),
    .i_push_data (bus.i_data),
    .i_pop       (load_s),
    .o_pop_data  (fifo_data_s),
    .o_full      (fifo_full_s),
    .o_empty     (fifo_empty_s),
    .o_level     (fifo_level_s)
  );

  // Serialiser next-state, bit timing and line level.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    shift_s     = shift_r;
    par_acc_s   = par_acc_r;
    stop_half_s = stop_half_r;
    tx_s        = tx_r;
    done_s      = 1'b0;
    load_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        tx_s  = 1'b1;
        cnt_s = {DIV_W{1'b0}};
        if (!fifo_empty_s) begin
          load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
          cnt_s   = {DIV_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
          tx_s    = shift_r[0];
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s     = {DIV_W{1'b0}};
          par_acc_s = par_acc_r ^ shift_r[0];
          if (idx_r == LAST_IDX) begin
            if (par_enabled(par_mode_r)) begin
              state_s = ST_PARITY;
              tx_s    = par_bit(par_mode_r, par_acc_r ^ shift_r[0]);
            end else begin
              state_s     = ST_STOP;
              tx_s        = 1'b1;
              stop_half_s = 1'b0;
            end
          end else begin
            idx_s   = idx_r + IDX_W'(1);
            shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end

      ST_PARITY: begin
        if (bit_end_s) begin
          state_s     = ST_STOP;
          cnt_s       = {DIV_W{1'b0}};
          tx_s        = 1'b1;
          stop_half_s = 1'b0;
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end_s) begin
          cnt_s = {DIV_W{1'b0}};
          // Two stop bits run the stop timer twice.
          if (stop2_r && !stop_half_r) begin
            stop_half_s = 1'b1;
          end else begin
            done_s = 1'b1;
            if (!fifo_empty_s) begin
              load_s = 1'b1;
            end else begin
              state_s = ST_IDLE;
              tx_s    = 1'b1;
            end
          end
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = {DIV_W{1'b0}};
        tx_s    = 1'b1;
      end
    endcase

    // Frame start: take the head word and freeze the run-time config.
    if (load_s) begin
      state_s     = ST_START;
      cnt_s       = {DIV_W{1'b0}};
      idx_s       = {IDX_W{1'b0}};
      shift_s     = fifo_data_s;
      par_acc_s   = 1'b0;
      stop_half_s = 1'b0;
      tx_s        = 1'b0;
      div_s       = div_eff_s;
      par_mode_s  = i_parity;
      stop2_s     = i_stop2;
    end else begin
      div_s      = div_r;
      par_mode_s = par_mode_r;
      stop2_s    = stop2_r;
    end

    busy_s = (state_s != ST_IDLE) || (lvl_next_s != {LVL_W{1'b0}});
  end

  // Serialiser registers; reset drives the line high at once and drops any frame.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {DIV_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      shift_r     <= {DATA_BITS{1'b0}};
      par_acc_r   <= 1'b0;
      stop_half_r <= 1'b0;
      div_r       <= {DIV_W{1'b0}};
      par_mode_r  <= PAR_NONE;
      stop2_r     <= 1'b0;
      tx_r        <= 1'b1;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      shift_r     <= shift_s;
      par_acc_r   <= par_acc_s;
      stop_half_r <= stop_half_s;
      div_r       <= div_s;
      par_mode_r  <= par_mode_s;
      stop2_r     <= stop2_s;
      tx_r        <= tx_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
    end
  end

  assign o_tx    = tx_r;
  assign o_done  = done_r;
  assign o_busy  = busy_r;
  assign o_level = fifo_level_s;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg with an 8-bit and a
// 5-bit instance. Expected line waveforms come from a frame model built from
// the word, divisor, parity mode and stop count.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div;
  logic [1:0]  par;
  logic        stop2;

  logic       tx8, busy8, done8;
  logic [2:0] lvl8;
  logic       tx5, busy5, done5;
  logic [2:0] lvl5;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt8 = 0;
  int   done_cnt5 = 0;
  bit   use5;
  int   cap_len;
  logic samp_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] drv_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) bus8();
  uart_tx_cfg_if #(.DATA_BITS(5)) bus5();

  uart_tx_cfg #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut8 (
    .i_wb_clk(clk), .i_rst_n(rst_n), .bus(bus8), .i_div(div), .i_parity(par),
    .i_stop2(stop2), .o_tx(tx8), .o_busy(busy8), .o_done(done8), .o_level(lvl8)
  );

  uart_tx_cfg #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIV_W(16)) dut5 (
    .i_wb_clk(clk), .i_rst_n(rst_n), .bus(bus5), .i_div(div), .i_parity(par),
    .i_stop2(stop2), .o_tx(tx5), .o_busy(busy5), .o_done(done5), .o_level(lvl5)
  );

  always @(posedge clk) begin
    if (done8 === 1'b1) done_cnt8 <= done_cnt8 + 1;
    if (done5 === 1'b1) done_cnt5 <= done_cnt5 + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic cur_tx();       return use5 ? tx5 : tx8;                     endfunction
  function automatic logic cur_done();     return use5 ? done5 : done8;                 endfunction
  function automatic logic cur_busy();     return use5 ? busy5 : busy8;                 endfunction
  function automatic logic cur_ready();    return use5 ? bus5.o_ready : bus8.o_ready;   endfunction
  function automatic logic [2:0] cur_lvl(); return use5 ? lvl5 : lvl8;                  endfunction
  function automatic int cur_done_cnt();   return use5 ? done_cnt5 : done_cnt8;         endfunction

  // Frame model: bit slot b = c / div; 0 start, 1..dbits data, optional parity, then stop.
  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int model_len(input int dbits, input int d, input int p, input int s2);
    return eff_div(d) * (1 + dbits + (((p == 1) || (p == 2)) ? 1 : 0) + ((s2 != 0) ? 2 : 1));
  endfunction

  function automatic logic model_line(input logic [8:0] w, input int dbits, input int d,
                                      input int p, input int c);
    int   b;
    logic x;
    b = c / eff_div(d);
    x = 1'b0;
    for (int i = 0; i < dbits; i++) x = x ^ w[i];
    if (b == 0) return 1'b0;
    if (b <= dbits) return w[b-1];
    if (((p == 1) || (p == 2)) && (b == dbits + 1)) return (p == 2) ? x : ~x;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_fall(input int limit);
    int n;
    n = 0;
    while ((cur_tx() !== 1'b0) && (n < limit)) begin
      tick();
      n++;
    end
    check("start bit seen", {31'd0, cur_tx() === 1'b0}, 32'd1);
  endtask

  // Records the line once per cycle from the start edge until o_done rises.
  task automatic capture();
    int n;
    n = 0;
    samp_q.delete();
    do begin
      samp_q.push_back(cur_tx());
      tick();
      n++;
    end while ((cur_done() !== 1'b1) && (n < 400));
    cap_len = n;
  endtask

  task automatic check_frame(input bit first, input int dbits, input int d,
                             input int p, input int s2);
    logic [8:0] w;
    int         bad;
    if (first) wait_fall(300);
    else check("contiguous start", {31'd0, cur_tx()}, 32'd0);
    check("word queued", {31'd0, exp_q.size() > 0}, 32'd1);
    w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'd0;
    capture();
    check("frame length", cap_len, model_len(dbits, d, p, s2));
    bad = 0;
    for (int c = 0; c < cap_len; c++) begin
      if (samp_q[c] !== model_line(w, dbits, d, p, c)) bad++;
    end
    check("frame waveform", bad, 32'd0);
  endtask

  // Holds i_valid high and advances through drv_q as words are accepted.
  task automatic drive_words();
    int i;
    int guard;
    logic rdy;
    i = 0;
    guard = 0;
    while ((i < drv_q.size()) && (guard < 3000)) begin
      if (use5) begin bus5.i_data = drv_q[i][4:0]; bus5.i_valid = 1'b1; end
      else      begin bus8.i_data = drv_q[i][7:0]; bus8.i_valid = 1'b1; end
      rdy = cur_ready();
      tick();
      guard++;
      if (rdy) begin
        exp_q.push_back(drv_q[i]);
        i++;
      end
    end
    bus5.i_valid = 1'b0;
    bus8.i_valid = 1'b0;
    check("all words accepted", i, drv_q.size());
  endtask

  typedef struct {
    int         dbits;
    logic [8:0] data;
    int         div;
    int         par;
    int         s2;
    int         len;
    int         has_par;
    int         pbit;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int base;
    int bad;
    int n;
    int nw;
    int dbits;

    vecs[0] = '{8, 9'h0A5, 4, 0, 0, 40, 0, 0};
    vecs[1] = '{8, 9'h007, 2, 2, 0, 22, 1, 1};
    vecs[2] = '{8, 9'h007, 2, 1, 0, 22, 1, 0};
    vecs[3] = '{8, 9'h007, 2, 2, 1, 24, 1, 1};
    vecs[4] = '{8, 9'h007, 2, 1, 1, 24, 1, 0};
    vecs[5] = '{8, 9'h000, 0, 0, 0, 20, 0, 0};
    vecs[6] = '{8, 9'h03C, 1, 1, 0, 22, 1, 1};
    vecs[7] = '{8, 9'h080, 5, 2, 1, 60, 1, 1};
    vecs[8] = '{5, 9'h01F, 3, 3, 0, 21, 0, 0};
    vecs[9] = '{5, 9'h00A, 2, 2, 1, 18, 1, 0};

    rst_n = 1'b0;
    use5  = 1'b0;
    div   = 16'd4;
    par   = 2'd0;
    stop2 = 1'b0;
    bus8.i_valid = 1'b0; bus8.i_data = 8'h00;
    bus5.i_valid = 1'b0; bus5.i_data = 5'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    check("reset tx", {31'd0, tx8}, 32'd1);
    check("reset done", {31'd0, done8}, 32'd0);
    check("reset busy", {31'd0, busy8}, 32'd0);
    check("reset level", {29'd0, lvl8}, 32'd0);
    check("reset ready", {31'd0, bus8.o_ready}, 32'd1);
    check("reset tx5", {31'd0, tx5}, 32'd1);

    // Single-frame vectors.
    for (int v = 0; v < 10; v++) begin
      use5  = (vecs[v].dbits == 5);
      div   = 16'(vecs[v].div);
      par   = 2'(vecs[v].par);
      stop2 = (vecs[v].s2 != 0);
      exp_q.delete();
      exp_q.push_back(vecs[v].data);
      base = cur_done_cnt();
      if (use5) begin bus5.i_data = vecs[v].data[4:0]; bus5.i_valid = 1'b1; end
      else      begin bus8.i_data = vecs[v].data[7:0]; bus8.i_valid = 1'b1; end
      tick();
      bus5.i_valid = 1'b0;
      bus8.i_valid = 1'b0;
      check("level after accept", {29'd0, cur_lvl()}, 32'd1);
      check("tx high at accept", {31'd0, cur_tx()}, 32'd1);
      tick();
      check("tx falls next edge", {31'd0, cur_tx()}, 32'd0);
      check_frame(1'b1, vecs[v].dbits, vecs[v].div, vecs[v].par, vecs[v].s2);
      check("table length", cap_len, vecs[v].len);
      if (vecs[v].has_par != 0)
        check("parity bit", {31'd0, samp_q[(vecs[v].dbits + 1) * eff_div(vecs[v].div)]},
              vecs[v].pbit);
      check("busy low at done", {31'd0, cur_busy()}, 32'd0);
      tick();
      check("done one cycle", {31'd0, cur_done()}, 32'd0);
      check("one done pulse", cur_done_cnt() - base, 32'd1);
    end

    // Back-to-back with queue filling: five contiguous frames.
    use5 = 1'b0; div = 16'd2; par = 2'd0; stop2 = 1'b0;
    exp_q.delete();
    drv_q = '{9'h011, 9'h0E2, 9'h033, 9'h0C4, 9'h055};
    base = done_cnt8;
    fork
      begin
        drive_words();
        check("level full", {29'd0, lvl8}, 32'd4);
        check("ready low when full", {31'd0, bus8.o_ready}, 32'd0);
        n = 0;
        while ((lvl8 == 3'd4) && (n < 100)) begin tick(); n++; end
        check("ready after pop", {31'd0, bus8.o_ready}, 32'd1);
        check("level after pop", {29'd0, lvl8}, 32'd3);
      end
      begin
        for (int f = 0; f < 5; f++) check_frame(f == 0, 8, 2, 0, 0);
        check("busy low after burst", {31'd0, busy8}, 32'd0);
        tick();
        check("done cleared", {31'd0, done8}, 32'd0);
        check("five done pulses", done_cnt8 - base, 32'd5);
      end
    join

    // Divisor latched at frame start: 3 for the first frame, 8 for the next.
    div = 16'd3;
    exp_q.delete();
    drv_q = '{9'h0C3};
    fork
      begin
        drive_words();
        repeat (6) tick();
        div = 16'd8;
        drv_q = '{9'h05A};
        drive_words();
      end
      begin
        check_frame(1'b1, 8, 3, 0, 0);
        check_frame(1'b0, 8, 8, 0, 0);
      end
    join
    tick();

    // Reset during DATA bit 3, with a second word still queued.
    div = 16'd4;
    exp_q.delete();
    drv_q = '{9'h000, 9'h0FF};
    drive_words();
    wait_fall(20);
    repeat (17) tick();
    check("tx low in bit 3", {31'd0, tx8}, 32'd0);
    base = done_cnt8;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset tx", {31'd0, tx8}, 32'd1);
    check("reset flushes level", {29'd0, lvl8}, 32'd0);
    check("reset clears busy", {31'd0, busy8}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if ((tx8 !== 1'b1) || (done8 !== 1'b0)) bad++;
    end
    check("line idle after reset", bad, 32'd0);
    check("no done after reset", done_cnt8 - base, 32'd0);
    check("level after reset", {29'd0, lvl8}, 32'd0);
    check("busy after reset", {31'd0, busy8}, 32'd0);

    // Random bursts against the frame model.
    for (int b = 0; b < 6; b++) begin
      use5  = ($urandom_range(0, 1) == 1);
      div   = 16'($urandom_range(0, 5));
      par   = 2'($urandom_range(0, 3));
      stop2 = ($urandom_range(0, 1) == 1);
      nw    = $urandom_range(1, 7);
      dbits = use5 ? 5 : 8;
      exp_q.delete();
      drv_q.delete();
      for (int i = 0; i < nw; i++)
        drv_q.push_back(use5 ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 255)));
      base = cur_done_cnt();
      fork
        drive_words();
        begin
          for (int f = 0; f < nw; f++) check_frame(f == 0, dbits, int'(div), int'(par), int'(stop2));
        end
      join
      tick();
      check("burst done pulses", cur_done_cnt() - base, nw);
      check("burst busy low", {31'd0, cur_busy()}, 32'd0);
      check("burst done low", {31'd0, cur_done()}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
